// File: rtl/ha_array_reducer.sv
// ha_array_reducer: final summation of four weighted half-adder row pairs into a 16-bit product.
// Latency: two register stages; a row set presented in cycle c is on p/out_valid in cycle c+2.
// Backpressure: p/ovf hold while out_ready=0; in_ready drops only when both stages are full and stalled.
// Build option: define HA_REDUCE_SAT_EN to saturate p to 16'hFFFF when the 17-bit sum overflows.
module ha_array_reducer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ha_array_0_b,
  input  logic [6:0]       ha_array_1_b,
  input  logic [6:0]       ha_array_2_b,
  input  logic [6:0]       ha_array_3_b,
  input  logic [8:0]       ha_array_0_t,
  input  logic [8:0]       ha_array_1_t,
  input  logic [8:0]       ha_array_2_t,
  input  logic [8:0]       ha_array_3_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      p,
  output logic             ovf,
  output logic [CNT_W-1:0] out_count
);

  // Unshifted row value: t plus carries weighted two places up; max 511 + 508 = 1019.
  function automatic logic [9:0] row_pre(input logic [6:0] b, input logic [8:0] t);
    return {1'b0, t} + {1'b0, b, 2'b00};
  endfunction

  logic [9:0]       pre0, pre1, pre2, pre3;
  logic             s1_vld_q, s1_vld_d;
  logic [12:0]      a_q, a_d;
  logic [16:0]      b_q, b_d;
  logic             s2_vld_q, s2_vld_d;
  logic [15:0]      p_q, p_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [16:0]      sum;
  logic             s1_load, s2_load, out_fire;

  assign pre0 = row_pre(ha_array_0_b, ha_array_0_t);
  assign pre1 = row_pre(ha_array_1_b, ha_array_1_t);
  assign pre2 = row_pre(ha_array_2_b, ha_array_2_t);
  assign pre3 = row_pre(ha_array_3_b, ha_array_3_t);

  // Stage 1 may accept whenever it is empty, stage 2 is empty, or stage 2 drains this cycle.
  assign in_ready = !s1_vld_q || !s2_vld_q || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_vld_q && (!s2_vld_q || out_ready);
  assign out_fire = s2_vld_q && out_ready;

  // Full-width final add; bit 16 is the overflow beyond the 16-bit product.
  assign sum = {4'b0000, a_q} + b_q;

  // Stage 1: pair rows 0+1 (13 bits) and rows 2+3 (17 bits) so no partial sum truncates.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    s1_vld_d = s1_vld_q;
    if (s1_load) begin
      a_d      = 13'(pre0) + {1'b0, pre1, 2'b00};
      b_d      = {3'b000, pre2, 4'b0000} + {1'b0, pre3, 6'b000000};
      s1_vld_d = 1'b1;
    end else if (s2_load) begin
      s1_vld_d = 1'b0;
    end
  end

  // Stage 2: final product and overflow flag; holds while the consumer stalls.
  always_comb begin
    p_d      = p_q;
    ovf_d    = ovf_q;
    s2_vld_d = s2_vld_q;
    if (s2_load) begin
`ifdef HA_REDUCE_SAT_EN
      p_d = sum[16] ? 16'hFFFF : sum[15:0];
`else
      p_d = sum[15:0];
`endif
      ovf_d    = sum[16];
      s2_vld_d = 1'b1;
    end else if (out_fire) begin
      s2_vld_d = 1'b0;
    end
  end

  // Completed output transfer counter, wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (out_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline and status registers with synchronous reset discarding in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      s2_vld_q <= 1'b0;
      p_q      <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s2_vld_q <= s2_vld_d;
      p_q      <= p_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign p         = p_q;
  assign ovf       = ovf_q;
  assign out_count = cnt_q;

endmodule
